// File: rtl/conv_psum_accumulator.sv
// Accumulates per-channel FP16 window sums from the PE adder tree into one
// output pixel per group (bias seed, optional ReLU) behind a 2-entry buffer.
// Ports: clk, rst (async, active-low); in_valid/tree_sum from the tree;
// cfg_num_ch, bias, relu_en, flush controls; out_valid/out_data/out_ready
// handshake; busy and sticky err_overflow status.

module FP_Add_16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Sum_Out
);
  logic [15:0] big, sml;
  logic [4:0]  xb, xs, d;
  logic [13:0] ab, as0, as;
  logic [14:0] s;
  logic [5:0]  e;
  logic [10:0] m;
  logic [11:0] m12;
  logic        sub, rnd;
  logic        nan_a, nan_b, inf_a, inf_b;

  always_comb begin
    nan_a = (&A[14:10]) && (|A[9:0]);
    nan_b = (&B[14:10]) && (|B[9:0]);
    inf_a = (&A[14:10]) && !(|A[9:0]);
    inf_b = (&B[14:10]) && !(|B[9:0]);
    if (A[14:0] >= B[14:0]) begin
      big = A;
      sml = B;
    end else begin
      big = B;
      sml = A;
    end
    xb  = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
    xs  = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
    d   = xb - xs;
    // 3 extra bits: guard, round, sticky
    ab  = {|big[14:10], big[9:0], 3'b000};
    as0 = {|sml[14:10], sml[9:0], 3'b000};
    if (d >= 5'd14) begin
      as = {13'd0, |as0};
    end else begin
      as    = as0 >> d;
      as[0] = as[0] | (|(as0 & ((14'd1 << d) - 14'd1)));
    end
    sub = big[15] ^ sml[15];
    s   = sub ? ({1'b0, ab} - {1'b0, as})
              : ({1'b0, ab} + {1'b0, as});
    e   = {1'b0, xb};
    if (s[14]) begin
      s = {1'b0, s[14:2], s[1] | s[0]};
      e = e + 6'd1;
    end
    // normalize left, stopping at the subnormal exponent
    for (int i = 0; i < 13; i++) begin
      if (!s[13] && (e > 6'd1)) begin
        s = s << 1;
        e = e - 6'd1;
      end
    end
    m   = s[13:3];
    rnd = s[2] && (s[1] || s[0] || s[3]);
    m12 = {1'b0, m} + {11'd0, rnd};
    if (m12[11]) begin
      m = m12[11:1];
      e = e + 6'd1;
    end else begin
      m = m12[10:0];
    end
    if (m == 11'd0)
      Sum_Out = {sub ? 1'b0 : big[15], 15'd0};
    else if (e >= 6'd31)
      Sum_Out = {big[15], 5'h1f, 10'd0};
    else
      Sum_Out = {big[15], m[10] ? e[4:0] : 5'd0, m[9:0]};
    if (nan_a)
      Sum_Out = A;
    else if (nan_b)
      Sum_Out = B;
    else if (inf_a && inf_b && (A[15] != B[15]))
      Sum_Out = 16'h7E00;
    else if (inf_a)
      Sum_Out = A;
    else if (inf_b)
      Sum_Out = B;
  end
endmodule

module conv_psum_accumulator #(
  parameter int TREE_LAT = 6,
  parameter int CH_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [15:0]     tree_sum,
  input  logic [CH_W-1:0] cfg_num_ch,
  input  logic [15:0]     bias,
  input  logic            relu_en,
  input  logic            flush,
  output logic            out_valid,
  output logic [15:0]     out_data,
  input  logic            out_ready,
  output logic            busy,
  output logic            err_overflow
);
  localparam logic [CH_W-1:0] ONE = CH_W'(1);

  logic [TREE_LAT-1:0] dl_q, dl_d;
  logic [CH_W-1:0]     cnt_q, cnt_d, n_q, n_d, n_eff;
  logic [15:0]         acc_q, acc_d, acc_sel, sum, push_val;
  logic [15:0]         b0_q, b0_d, b1_q, b1_d;
  logic [1:0]          occ_q, occ_d;
  logic                err_q, err_d;
  logic                v_al, last, push, pop;

  assign v_al    = dl_q[TREE_LAT-1];
  assign acc_sel = (cnt_q == '0) ? bias : acc_q;

  FP_Add_16 u_add (
    .A       (acc_sel),
    .B       (tree_sum),
    .Sum_Out (sum)
  );

  // group length is latched on the first channel of each group
  assign n_eff = (cnt_q != '0) ? n_q :
                 (cfg_num_ch == '0) ? ONE : cfg_num_ch;
  assign last     = v_al && (cnt_q == n_eff - ONE);
  assign push     = last;
  assign push_val = (relu_en && sum[15]) ? 16'h0000 : sum;
  assign pop      = (occ_q != 2'd0) && out_ready;

  assign out_valid    = (occ_q != 2'd0);
  assign out_data     = out_valid ? b0_q : 16'h0000;
  assign busy         = (cnt_q != '0) || (|dl_q);
  assign err_overflow = err_q;

  always_comb begin
    dl_d    = dl_q << 1;
    dl_d[0] = in_valid;
    cnt_d   = cnt_q;
    n_d     = n_q;
    acc_d   = acc_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    occ_d   = occ_q;
    err_d   = err_q;
    if (v_al) begin
      acc_d = sum;
      n_d   = n_eff;
      cnt_d = last ? '0 : cnt_q + ONE;
    end
    unique case ({push, pop})
      2'b11: begin
        if (occ_q == 2'd2) begin
          b0_d = b1_q;
          b1_d = push_val;
        end else begin
          b0_d = push_val;
        end
      end
      2'b10: begin
        unique case (occ_q)
          2'd0: begin
            b0_d  = push_val;
            occ_d = 2'd1;
          end
          2'd1: begin
            b1_d  = push_val;
            occ_d = 2'd2;
          end
          default: err_d = 1'b1;
        endcase
      end
      2'b01: begin
        b0_d  = b1_q;
        b1_d  = 16'h0000;
        occ_d = occ_q - 2'd1;
      end
      default: ;
    endcase
    if (flush) begin
      dl_d  = '0;
      cnt_d = '0;
      acc_d = 16'h0000;
      b0_d  = 16'h0000;
      b1_d  = 16'h0000;
      occ_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_q  <= '0;
      cnt_q <= '0;
      n_q   <= '0;
      acc_q <= 16'h0000;
      b0_q  <= 16'h0000;
      b1_q  <= 16'h0000;
      occ_q <= 2'd0;
      err_q <= 1'b0;
    end else begin
      dl_q  <= dl_d;
      cnt_q <= cnt_d;
      n_q   <= n_d;
      acc_q <= acc_d;
      b0_q  <= b0_d;
      b1_q  <= b1_d;
      occ_q <= occ_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/conv_psum_accumulator.md
Name: conv_psum_accumulator

Overview:
- Sits directly downstream of the 49-input pipelined FP16 adder tree of the PE.
- Realigns a valid tag with the tree's fixed-latency result.
- Accumulates one FP16 7x7 window sum per input channel over cfg_num_ch channels, seeded with a per-group bias, and applies optional ReLU.
- Hands each finished output pixel to the next stage through a 2-entry valid/ready output buffer, because the tree itself cannot stall.

Parameters:
- TREE_LAT, 6, cycles from tree input to tree final_sum; depth of the tag delay line.
- CH_W, 8, width of the channel counter and cfg_num_ch.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- in_valid  input  1  high in the cycle a channel's window data enters the adder tree
- tree_sum  input  16  FP16 final_sum from the adder tree
- cfg_num_ch  input  CH_W  channels per output pixel; 0 is treated as 1
- bias  input  16  FP16 bias for the current group
- relu_en  input  1  1 = clamp negative results to +0
- flush  input  1  synchronous soft clear
- out_valid  output  1  output buffer non-empty
- out_data  output  16  FP16 result at the buffer head
- out_ready  input  1  downstream accepts out_data
- busy  output  1  group in progress or tags in flight
- err_overflow  output  1  sticky: a finished result was dropped

Behaviour:
- Reset (rst=0, async): delay line, channel counter, accumulator, buffer and err_overflow cleared; out_valid=0, out_data=0x0000, busy=0, err_overflow=0. Reset mid-group discards all partial state; no output is produced for that group.
- Tag alignment:
  - in_valid feeds a TREE_LAT-deep shift register; its tail is v_al.
  - v_al is high exactly in the cycle tree_sum holds that channel's sum.
  - Back-to-back and gapped in_valid must both align.
- Arithmetic:
  - One combinational FP_Add_16 instance (A, B, Sum_Out).
  - A = acc_sel, where acc_sel = bias when ch_cnt==0, else acc.
  - B = tree_sum.
  - On v_al: acc <= Sum_Out and ch_cnt increments.
  - Addition order is fixed: (((bias+s0)+s1)+...+sN-1). The bench compares bit-exactly against this order.
- Configuration:
  - bias and cfg_num_ch are sampled only on a v_al cycle with ch_cnt==0.
  - The latched N = max(cfg_num_ch,1) holds for the whole group.
  - Changes mid-group are ignored.
- Group completion:
  - On a v_al cycle with ch_cnt==N-1: ch_cnt <= 0.
  - The pushed value is relu(Sum_Out): if relu_en and Sum_Out[15]==1 (including -0 and negative NaN), push 0x0000; else push Sum_Out unmodified.
  - relu_en is sampled in the push cycle.
  - out_valid rises the cycle after the push. Last-channel in_valid to out_valid latency is TREE_LAT+1 cycles.
- Output buffer (2 entries, FIFO order):
  - out_valid = not empty; out_data = head entry, 0x0000 when empty.
  - Pop on out_valid && out_ready.
  - Push when full with a pop in the same cycle: accepted, occupancy stays 2.
  - Push when full without a pop: result dropped, err_overflow <= 1, and it stays 1 until rst. Flush does not clear it.
  - out_data must remain stable while out_valid && !out_ready.
- busy = (ch_cnt != 0) or any delay-line bit set.
- flush (synchronous, highest priority over v_al and push):
  - Clears the delay line, ch_cnt, acc and the buffer.
  - out_valid is 0 the next cycle.
- Non-finite values pass through FP_Add_16 unmodified; the block does not detect them.

Test Plan:
- Basic sum: cfg_num_ch=3, bias=0x3C00, three in_valid pulses, tree_sum=0x3C00 each at aligned cycles, out_ready=1 -> one out_valid pulse with out_data=0x4400 (4.0), exactly TREE_LAT+1 cycles after the 3rd in_valid.
- ReLU: cfg_num_ch=1, bias=0xBC00, tree_sum=0xC000 -> 0xC200 with relu_en=0; the same stimulus with relu_en=1 -> 0x0000.
- Alignment:
  - in_valid pattern 1,0,1,1,0,1 with cfg_num_ch=2, bias=0x0000, tree_sum=0x3800 only at aligned cycles and garbage 0x7BFF elsewhere.
  - Required: two results, each 0x3C00, with no garbage absorbed.
  - cfg_num_ch=0 with a single pulse -> exactly one result.
- Backpressure and overflow:
  - out_ready=0, three groups with cfg_num_ch=1, bias=0, sums 0x3C00, 0x4000, 0x4200.
  - Required: err_overflow=1 after the third group, and out_data held at 0x3C00.
  - Raising out_ready then yields 0x3C00 followed by 0x4000, then out_valid=0.
  - Simultaneous push+pop when full is accepted with no error.
- Reset and flush mid-group:
  - With cfg_num_ch=4, after 2 channels assert rst=0 for 1 cycle: all outputs are 0 immediately and busy=0.
  - Then a fresh 4-channel group of 0x3C00 with bias 0 -> 0x4400.
  - Repeat the same sequence using flush instead: identical result, and err_overflow retains its prior value.
